// File: rtl/aer_fifo_drain_ctrl_pkg.sv
// Shared types and defaults for the AER FIFO drain controller.
package aer_fifo_drain_ctrl_pkg;

  typedef enum logic [1:0] {
    DRN_IDLE  = 2'd0,
    DRN_BURST = 2'd1,
    DRN_GAP   = 2'd2
  } drain_state_t;

  localparam int DRAIN_MAX_BURST_DEF = 16;
  localparam int DRAIN_DWIDTH_DEF    = 64;
  localparam int DRAIN_DEPTH_DEF     = 64;
  localparam int DRAIN_TO_WIDTH_DEF  = 16;

endpackage

// File: rtl/aer_fifo_drain_ctrl_if.sv
// FIFO-read and output-stream signals between the drain controller and its neighbours.
interface aer_fifo_drain_ctrl_if #(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 64
);
  localparam int AWIDTH = $clog2(DEPTH);

  logic              fifo_empty;
  logic [AWIDTH:0]   fifo_numel;
  logic [DWIDTH-1:0] fifo_rdata;
  logic              fifo_rd_en;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_last;

  modport master (
    input  fifo_empty, fifo_numel, fifo_rdata, out_ready,
    output fifo_rd_en, out_valid, out_data, out_last
  );

  modport slave (
    output fifo_empty, fifo_numel, fifo_rdata, out_ready,
    input  fifo_rd_en, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aer_drain_timer.sv
// Saturating idle counter; expired once it has counted cfg_timeout-1 cycles (0 disables).
module aer_drain_timer #(
  parameter int TO_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [TO_WIDTH-1:0] cfg_timeout,
  output logic                expired
);
  logic [TO_WIDTH-1:0] cnt_r;

  // Idle-cycle counter, held at all-ones once saturated
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != {TO_WIDTH{1'b1}})) begin
      cnt_r <= cnt_r + TO_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cfg_timeout != '0) && (cnt_r >= (cfg_timeout - TO_WIDTH'(1)));
endmodule

// File: rtl/aer_fifo_drain_ctrl.sv
// Drains an FWFT FIFO in bounded bursts onto a valid/ready stream with a last marker.
module aer_fifo_drain_ctrl
  import aer_fifo_drain_ctrl_pkg::*;
#(
  parameter int  DWIDTH    = DRAIN_DWIDTH_DEF,
  parameter int  DEPTH     = DRAIN_DEPTH_DEF,
  parameter int  MAX_BURST = DRAIN_MAX_BURST_DEF,
  parameter int  TO_WIDTH  = DRAIN_TO_WIDTH_DEF,
  localparam int AWIDTH    = $clog2(DEPTH),
  localparam int BWIDTH    = $clog2(MAX_BURST) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_enable,
  input  logic [AWIDTH:0]      cfg_threshold,
  input  logic [TO_WIDTH-1:0]  cfg_timeout,
  input  logic                 soft_clr,
  aer_fifo_drain_ctrl_if.master bus,
  output logic                 busy,
  output logic [15:0]          burst_cnt
);
  localparam logic [AWIDTH:0] MAX_BURST_A = (AWIDTH+1)'(MAX_BURST);
  localparam logic [AWIDTH:0] ONE_A       = (AWIDTH+1)'(1);

  drain_state_t      state_r;
  logic [BWIDTH-1:0] beats_left_r;
  logic [15:0]       burst_cnt_r;

  logic [AWIDTH:0]   thr_eff_s;
  logic [AWIDTH:0]   start_beats_s;
  logic              thr_hit_s;
  logic              to_exp_s;
  logic              to_hit_s;
  logic              in_idle_s;
  logic              trig_s;
  logic              valid_s;
  logic              last_s;
  logic              rd_s;
  logic [DWIDTH-1:0] data_s;

  assign in_idle_s     = (state_r == DRN_IDLE);
  assign thr_eff_s     = (cfg_threshold == '0) ? ONE_A : cfg_threshold;
  assign thr_hit_s     = cfg_enable && (bus.fifo_numel >= thr_eff_s);
  assign to_hit_s      = cfg_enable && !bus.fifo_empty && to_exp_s;
  assign trig_s        = in_idle_s && (thr_hit_s || to_hit_s);
  assign start_beats_s = (bus.fifo_numel < MAX_BURST_A) ? bus.fifo_numel : MAX_BURST_A;

  aer_drain_timer #(
    .TO_WIDTH (TO_WIDTH)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clr         (soft_clr || !in_idle_s || bus.fifo_empty || !cfg_enable || trig_s),
    .en          (in_idle_s && !bus.fifo_empty && !thr_hit_s),
    .cfg_timeout (cfg_timeout),
    .expired     (to_exp_s)
  );

  // Stream side follows the FWFT head; soft_clr kills a beat in flight so no last escapes
  always_comb begin
    valid_s = 1'b0;
    data_s  = '0;
    last_s  = 1'b0;
    rd_s    = 1'b0;
    if ((state_r == DRN_BURST) && !soft_clr) begin
      valid_s = !bus.fifo_empty;
      data_s  = bus.fifo_rdata;
      last_s  = valid_s && (beats_left_r == BWIDTH'(1));
      rd_s    = valid_s && bus.out_ready;
    end else begin
      valid_s = 1'b0;
    end
  end

  assign bus.out_valid  = valid_s;
  assign bus.out_data   = data_s;
  assign bus.out_last   = last_s;
  assign bus.fifo_rd_en = rd_s;

  // Burst sequencer: IDLE evaluates triggers, BURST counts beats, GAP lets FIFO status settle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= DRN_IDLE;
      beats_left_r <= '0;
      burst_cnt_r  <= 16'd0;
    end else if (soft_clr) begin
      state_r      <= DRN_IDLE;
      beats_left_r <= '0;
    end else begin
      case (state_r)
        DRN_IDLE: begin
          if (trig_s) begin
            beats_left_r <= BWIDTH'(start_beats_s);
            state_r      <= DRN_BURST;
          end else begin
            state_r      <= DRN_IDLE;
          end
        end
        DRN_BURST: begin
          if (rd_s) begin
            beats_left_r <= beats_left_r - BWIDTH'(1);
            if (last_s) begin
              burst_cnt_r <= burst_cnt_r + 16'd1;
              state_r     <= DRN_GAP;
            end else begin
              state_r     <= DRN_BURST;
            end
          end else begin
            state_r <= DRN_BURST;
          end
        end
        DRN_GAP: begin
          state_r <= DRN_IDLE;
        end
        default: begin
          state_r      <= DRN_IDLE;
          beats_left_r <= '0;
        end
      endcase
    end
  end

  assign busy      = !in_idle_s;
  assign burst_cnt = burst_cnt_r;
endmodule
